// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
//
// This is a run-time configurable counter for the temperature-sensor datapath.
// It provides sample-interval timing and bit/word indexing for the ADC and
// serial sequencing logic. Its features are:
//   - count enable
//   - parallel load
//   - up/down direction
//   - a run-time terminal value
//   - wrap or saturate at the boundary
//   - a built-in prescaler
//   - a registered one-cycle terminal-count pulse
//
// Parameters
//   DATA_WIDTH : width of out, max_val and load_val (>= 1)
//   PRESCALE   : number of enabled cycles per count step (>= 1)
//
// Ports
//   clk      : sole clock, rising edge
//   rst      : synchronous, active-high reset
//   en       : count enable; advances the prescaler and gates steps
//   load     : parallel load strobe (overrides en)
//   load_val : value written on load (not clamped to max_val)
//   dir      : 1 = count up, 0 = count down
//   max_val  : run-time terminal value, sampled on every step
//   sat      : 1 = saturate at the boundary, 0 = wrap
//   out      : registered count
//   tc       : registered terminal-count pulse, one cycle wide
//
// Priority at each edge is rst > load > step > hold.
// -----------------------------------------------------------------------------
module mod_counter #(
    parameter int DATA_WIDTH = 10,
    parameter int PRESCALE   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_val,
    input  logic                  dir,
    input  logic [DATA_WIDTH-1:0] max_val,
    input  logic                  sat,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  tc
);

    // The prescaler needs at least one bit, even when PRESCALE == 1.
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0]      PRE_ONE  = PRE_W'(1);
    localparam logic [DATA_WIDTH-1:0] CNT_ONE  = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] CNT_ZERO = '0;

    logic [PRE_W-1:0]      pre;
    logic [PRE_W-1:0]      pre_nxt;
    logic                  step;
    logic [DATA_WIDTH-1:0] step_out;
    logic                  step_tc;

    // A step happens on the enabled cycle in which the prescaler is at its
    // last value. With PRESCALE == 1, pre stays at 0 and every enabled cycle
    // is a step.
    assign step = en && (pre == PRE_LAST);

    always_comb begin
        pre_nxt = pre + PRE_ONE;
        if (pre == PRE_LAST) begin
            pre_nxt = '0;
        end
    end

    // Next count and terminal-count flag, used only when a step occurs.
    always_comb begin
        step_out = out;
        step_tc  = 1'b0;
        if (dir) begin
            // Counting up.
            if (out < max_val) begin
                step_out = out + CNT_ONE;
                // In saturate mode, tc marks arrival at the top.
                step_tc  = sat && ((out + CNT_ONE) == max_val);
            end else if (!sat) begin
                // At or above the terminal value: wrap to 0.
                step_out = CNT_ZERO;
                step_tc  = 1'b1;
            end else begin
                // At or above the terminal value: clamp to it.
                step_out = max_val;
                step_tc  = 1'b0;
            end
        end else begin
            // Counting down.
            if (out > max_val) begin
                // A value loaded above the terminal value snaps back to it,
                // in both modes.
                step_out = max_val;
                step_tc  = 1'b0;
            end else if (out != CNT_ZERO) begin
                step_out = out - CNT_ONE;
                // In saturate mode, tc marks arrival at 0.
                step_tc  = sat && ((out - CNT_ONE) == CNT_ZERO);
            end else if (!sat) begin
                // At 0: wrap to the terminal value.
                step_out = max_val;
                step_tc  = 1'b1;
            end else begin
                // At 0: stay there.
                step_out = CNT_ZERO;
                step_tc  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
            tc  <= 1'b0;
            pre <= '0;
        end else if (load) begin
            // Load restarts the prescaler, so the next step needs a full
            // PRESCALE enabled cycles.
            out <= load_val;
            tc  <= 1'b0;
            pre <= '0;
        end else begin
            if (en) begin
                pre <= pre_nxt;
            end
            if (step) begin
                out <= step_out;
            end
            // tc is a single-cycle pulse, so it is cleared on every
            // non-step cycle.
            tc <= step && step_tc;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_counter
//
// This bench drives two counters from the same inputs. Both have a 4-bit
// count. Instance a uses PRESCALE = 1 and instance b uses PRESCALE = 3.
//
// A behavioural reference model tracks both instances. It follows the
// counting rules with plain integer arithmetic. Directed scenarios compare
// against constant sequences, and the random scenario compares against the
// model.
// -----------------------------------------------------------------------------
module tb_mod_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         load;
    logic [W-1:0] load_val;
    logic         dir;
    logic [W-1:0] max_val;
    logic         sat;
    logic [W-1:0] out_a;
    logic [W-1:0] out_b;
    logic         tc_a;
    logic         tc_b;

    int errors = 0;
    int checks = 0;

    // Reference model state: index 0 tracks instance a, index 1 tracks
    // instance b. m_cnt counts enabled cycles since the last step, load or
    // reset.
    int ps    [2] = '{1, 3};
    int m_out [2];
    int m_tc  [2];
    int m_cnt [2];

    // ------------------------------------------------------------------ clock
    always #5 clk = ~clk;

    mod_counter #(.DATA_WIDTH(W), .PRESCALE(1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .dir(dir), .max_val(max_val), .sat(sat), .out(out_a), .tc(tc_a)
    );

    mod_counter #(.DATA_WIDTH(W), .PRESCALE(3)) dut_b (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .dir(dir), .max_val(max_val), .sat(sat), .out(out_b), .tc(tc_b)
    );

    // ------------------------------------------------------- reference model
    // Apply one step to model instance k, using the rules written in terms of
    // the count value and the current max_val, dir and sat.
    task automatic model_step(input int k);
        int mx;
        mx = int'(max_val);
        if (dir) begin
            if (m_out[k] < mx) begin
                m_out[k] = m_out[k] + 1;
                m_tc[k]  = (sat && m_out[k] == mx) ? 1 : 0;
            end else if (!sat) begin
                m_out[k] = 0;
                m_tc[k]  = 1;
            end else begin
                m_out[k] = mx;
                m_tc[k]  = 0;
            end
        end else begin
            if (m_out[k] > mx) begin
                m_out[k] = mx;
                m_tc[k]  = 0;
            end else if (m_out[k] > 0) begin
                m_out[k] = m_out[k] - 1;
                m_tc[k]  = (sat && m_out[k] == 0) ? 1 : 0;
            end else if (!sat) begin
                m_out[k] = mx;
                m_tc[k]  = 1;
            end else begin
                m_tc[k]  = 0;
            end
        end
    endtask

    // Advance one clock edge: update the model from the inputs present at the
    // edge, then wait 1 time unit so that DUT outputs are sampled away from
    // the edge.
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            m_tc[k] = 0;
            if (rst) begin
                m_out[k] = 0;
                m_cnt[k] = 0;
            end else if (load) begin
                m_out[k] = int'(load_val);
                m_cnt[k] = 0;
            end else if (en) begin
                m_cnt[k] = m_cnt[k] + 1;
                if (m_cnt[k] == ps[k]) begin
                    m_cnt[k] = 0;
                    model_step(k);
                end
            end
        end
        #1;
    endtask

    // ---------------------------------------------------------------- drivers
    task automatic drive_idle();
        rst = 1'b0; en = 1'b0; load = 1'b0; load_val = '0;
        dir = 1'b1; max_val = '0; sat = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load = 1'b1; load_val = v;
        tick();
        load = 1'b0;
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        en  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        en  = 1'b0;
        checks++;
        if (out_a !== 4'd0 || tc_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: out=%0d tc=%0b, expected out=0 tc=0", out_a, tc_a);
        end
        checks++;
        if (out_b !== 4'd0 || tc_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: out=%0d tc=%0b, expected out=0 tc=0", out_b, tc_b);
        end
    endtask

    // Instance a: max 8, counting up, wrap mode. The count runs 1..8, 0, 1,
    // and the period is 9 cycles.
    task automatic test_wrap_up();
        drive_idle();
        do_reset();
        max_val = 4'd8; dir = 1'b1; sat = 1'b0; en = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            checks++;
            if (out_a !== 4'(i % 9) || tc_a !== ((i % 9) == 0)) begin
                errors++;
                $display("FAIL wrap_up[%0d]: out=%0d tc=%0b, expected out=%0d tc=%0b",
                         i, out_a, tc_a, i % 9, (i % 9) == 0);
            end
        end
        en = 1'b0;
    endtask

    // Instance b: PRESCALE 3, max 2. Dropping en for 2 cycles stretches the
    // current interval by exactly 2 cycles.
    task automatic test_prescale();
        int exp_o [11] = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 0};
        int en_v  [11] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        drive_idle();
        do_reset();
        max_val = 4'd2; dir = 1'b1; sat = 1'b0;
        for (int i = 0; i < 11; i++) begin
            en = en_v[i][0];
            tick();
            checks++;
            if (out_b !== 4'(exp_o[i]) || tc_b !== (i == 10)) begin
                errors++;
                $display("FAIL prescale[%0d]: out=%0d tc=%0b, expected out=%0d tc=%0b",
                         i, out_b, tc_b, exp_o[i], i == 10);
            end
        end
        en = 1'b0;
    endtask

    // Instance a: load 1, then count down in wrap mode with max 5.
    // The count goes 1, 0, 5, 4, and tc is high with the 5.
    task automatic test_down_wrap();
        int exp_o [4] = '{1, 0, 5, 4};
        int exp_t [4] = '{0, 0, 1, 0};
        drive_idle();
        max_val = 4'd5; dir = 1'b0; sat = 1'b0;
        do_load(4'd1);
        checks++;
        if (out_a !== 4'd1 || tc_a !== 1'b0) begin
            errors++;
            $display("FAIL down_load: out=%0d tc=%0b, expected out=1 tc=0", out_a, tc_a);
        end
        en = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++;
            if (out_a !== 4'(exp_o[i]) || tc_a !== exp_t[i][0]) begin
                errors++;
                $display("FAIL down_wrap[%0d]: out=%0d tc=%0b, expected out=%0d tc=%0d",
                         i, out_a, tc_a, exp_o[i], exp_t[i]);
            end
        end
        en = 1'b0;
    endtask

    // Instance a: saturate mode, counting up with max 3. The count goes
    // 1, 2, 3, 3, 3, and tc is high only with the first 3.
    task automatic test_saturate();
        int exp_o [5] = '{1, 2, 3, 3, 3};
        int exp_t [5] = '{0, 0, 1, 0, 0};
        drive_idle();
        do_reset();
        max_val = 4'd3; dir = 1'b1; sat = 1'b1; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_a !== 4'(exp_o[i]) || tc_a !== exp_t[i][0]) begin
                errors++;
                $display("FAIL saturate[%0d]: out=%0d tc=%0b, expected out=%0d tc=%0d",
                         i, out_a, tc_a, exp_o[i], exp_t[i]);
            end
        end
        en = 1'b0;
    endtask

    // Instance a: load a value above max_val, then take one step up and one
    // step down.
    task automatic test_load_above();
        drive_idle();
        max_val = 4'd7; sat = 1'b0; dir = 1'b1;
        do_load(4'd12);
        en = 1'b1;
        tick();
        en = 1'b0;
        checks++;
        if (out_a !== 4'd0 || tc_a !== 1'b1) begin
            errors++;
            $display("FAIL above_up: out=%0d tc=%0b, expected out=0 tc=1", out_a, tc_a);
        end
        dir = 1'b0;
        do_load(4'd12);
        en = 1'b1;
        tick();
        en = 1'b0;
        checks++;
        if (out_a !== 4'd7 || tc_a !== 1'b0) begin
            errors++;
            $display("FAIL above_down: out=%0d tc=%0b, expected out=7 tc=0", out_a, tc_a);
        end
    endtask

    // Simultaneous events: load with en, rst with load, and rst mid-count.
    task automatic test_simultaneous();
        drive_idle();
        max_val = 4'd15; dir = 1'b1;
        en = 1'b1; load = 1'b1; load_val = 4'd9;
        tick();
        load = 1'b0;
        checks++;
        if (out_a !== 4'd9 || out_b !== 4'd9 || tc_a !== 1'b0) begin
            errors++;
            $display("FAIL load_en: out_a=%0d out_b=%0d tc_a=%0b, expected 9 9 0",
                     out_a, out_b, tc_a);
        end
        rst = 1'b1; load = 1'b1; load_val = 4'd6;
        tick();
        rst = 1'b0; load = 1'b0;
        checks++;
        if (out_a !== 4'd0 || out_b !== 4'd0) begin
            errors++;
            $display("FAIL rst_load: out_a=%0d out_b=%0d, expected 0 0", out_a, out_b);
        end
        // Count instance b to 1 and leave its prescaler partway through an
        // interval.
        en = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_b !== 4'd0 || tc_b !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: out_b=%0d tc_b=%0b, expected out=0 tc=0", out_b, tc_b);
        end
        // After reset, the first step needs a full 3 enabled cycles.
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (out_b !== 4'(i / 3)) begin
                errors++;
                $display("FAIL rst_restart[%0d]: out_b=%0d, expected %0d", i, out_b, i / 3);
            end
        end
        en = 1'b0;
    endtask

    // Random stimulus checked against the reference model on every cycle,
    // for both instances.
    task automatic test_random();
        int bad;
        bad = 0;
        drive_idle();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 99) == 0);
            load     = ($urandom_range(0, 15) == 0);
            load_val = 4'($urandom_range(0, 15));
            en       = ($urandom_range(0, 3) != 0);
            if ((i / 200) % 3 == 0) begin
                // Hold the configuration steady within a block.
                dir     = ((i / 200) % 2 == 0);
                sat     = ((i / 600) % 2 == 1);
                max_val = 4'((i / 200) % 16);
            end else begin
                dir     = ($urandom_range(0, 7) != 0) ? dir : ~dir;
                sat     = ($urandom_range(0, 15) != 0) ? sat : ~sat;
                max_val = ($urandom_range(0, 15) != 0) ? max_val
                                                       : 4'($urandom_range(0, 15));
            end
            tick();
            checks++;
            if (out_a !== 4'(m_out[0]) || tc_a !== m_tc[0][0] ||
                out_b !== 4'(m_out[1]) || tc_b !== m_tc[1][0]) begin
                errors++;
                bad++;
                if (bad <= 10) begin
                    $display("FAIL random[%0d]: a out=%0d tc=%0b b out=%0d tc=%0b, expected a %0d %0d b %0d %0d",
                             i, out_a, tc_a, out_b, tc_b, m_out[0], m_tc[0], m_out[1], m_tc[1]);
                end
            end
        end
        drive_idle();
    endtask

    // -------------------------------------------------------------- sequence
    initial begin
        for (int k = 0; k < 2; k++) begin
            m_out[k] = 0;
            m_tc[k]  = 0;
            m_cnt[k] = 0;
        end
        drive_idle();
        #2;
        test_reset();
        test_wrap_up();
        test_prescale();
        test_down_wrap();
        test_saturate();
        test_load_above();
        test_simultaneous();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
